// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_if
// Description : IFU/LSU request-response channels plus the shared SRAM port.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic        ifu_resp_ready;
    logic [31:0] ifu_resp_data;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_addr;
    logic [31:0] lsu_req_len;
    logic [31:0] lsu_req_wdata;
    logic        lsu_resp_valid;
    logic        lsu_resp_ready;
    logic [31:0] lsu_resp_data;

    logic        mem_load;
    logic        mem_store;
    logic [31:0] mem_addr;
    logic [31:0] mem_len;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_len, lsu_req_wdata,
        input  lsu_resp_ready, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        output mem_load, mem_store, mem_addr, mem_len, mem_wdata
    );

    // IFU / LSU / SRAM side
    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_len, lsu_req_wdata,
        output lsu_resp_ready, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        input  mem_load, mem_store, mem_addr, mem_len, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Round-robin IFU/LSU arbiter for the single SRAM port with a
//               fixed access latency and valid/ready response channels.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int LATENCY = 1,
    parameter int IFU_LEN = 4
) (
    input  wire logic      clock,
    input  wire logic      reset,   // active-low, asynchronous
    sram_arbiter_if.slave  bus
);
    localparam int   CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic c_OWNER_IFU = 1'b0;
    localparam logic c_OWNER_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_last_grant;
    logic               r_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mem_load;
    logic               r_mem_store;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_len;
    logic [31:0]        r_mem_wdata;
    logic [31:0]        r_rdata;
    logic               r_ifu_resp_valid;
    logic               r_lsu_resp_valid;

    logic               w_idle;
    logic               w_grant_ifu;
    logic               w_grant_lsu;
    logic               w_resp_done;

    // Ready is gated by reset so neither master sees a grant while held in reset.
    assign w_idle      = reset && (r_state == S_IDLE);
    assign w_grant_ifu = w_idle && bus.ifu_req_valid &&
                         (!bus.lsu_req_valid || (r_last_grant == c_OWNER_LSU));
    assign w_grant_lsu = w_idle && bus.lsu_req_valid &&
                         (!bus.ifu_req_valid || (r_last_grant == c_OWNER_IFU));
    assign w_resp_done = (r_owner == c_OWNER_IFU) ? bus.ifu_resp_ready : bus.lsu_resp_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_last_grant     <= c_OWNER_LSU;
            r_owner          <= c_OWNER_IFU;
            r_cnt            <= '0;
            r_mem_load       <= 1'b0;
            r_mem_store      <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_len        <= '0;
            r_mem_wdata      <= '0;
            r_rdata          <= '0;
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
        end else begin
            r_mem_load  <= 1'b0;
            r_mem_store <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ifu) begin
                        r_owner      <= c_OWNER_IFU;
                        r_last_grant <= c_OWNER_IFU;
                        r_mem_addr   <= bus.ifu_req_addr;
                        r_mem_len    <= 32'(IFU_LEN);
                        r_mem_wdata  <= '0;
                        r_mem_load   <= 1'b1;
                        r_cnt        <= CNT_W'(LATENCY - 1);
                        r_state      <= S_ACCESS;
                    end else if (w_grant_lsu) begin
                        r_owner      <= c_OWNER_LSU;
                        r_last_grant <= c_OWNER_LSU;
                        r_mem_addr   <= bus.lsu_req_addr;
                        r_mem_len    <= bus.lsu_req_len;
                        r_mem_wdata  <= bus.lsu_req_wdata;
                        r_mem_load   <= !bus.lsu_req_wen;
                        r_mem_store  <= bus.lsu_req_wen;
                        r_cnt        <= CNT_W'(LATENCY - 1);
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // The strobe is only high in the first ACCESS cycle.
                    if (r_mem_load) begin
                        r_rdata <= bus.mem_rdata;
                    end else if (r_mem_store) begin
                        r_rdata <= '0;
                    end
                    if (r_cnt == '0) begin
                        r_ifu_resp_valid <= (r_owner == c_OWNER_IFU);
                        r_lsu_resp_valid <= (r_owner == c_OWNER_LSU);
                        r_state          <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_resp_done) begin
                        r_ifu_resp_valid <= 1'b0;
                        r_lsu_resp_valid <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ifu_req_ready  = w_grant_ifu;
    assign bus.lsu_req_ready  = w_grant_lsu;
    assign bus.ifu_resp_valid = r_ifu_resp_valid;
    assign bus.lsu_resp_valid = r_lsu_resp_valid;
    assign bus.ifu_resp_data  = r_rdata;
    assign bus.lsu_resp_data  = r_rdata;
    assign bus.mem_load       = r_mem_load;
    assign bus.mem_store      = r_mem_store;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_len        = r_mem_len;
    assign bus.mem_wdata      = r_mem_wdata;
endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed scoreboard bench for sram_arbiter (LATENCY 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;
    localparam int L_A = 1;
    localparam int L_B = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    typedef struct {
        logic        owner;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] len;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cyc;
    } txn_t;

    txn_t q_strb[$];
    txn_t q_resp[$];
    logic q_grant[$];

    sram_arbiter_if a();
    sram_arbiter_if b();

    sram_arbiter #(.LATENCY(L_A), .IFU_LEN(4)) dut_a (.clock(clock), .reset(reset), .bus(a.slave));
    sram_arbiter #(.LATENCY(L_B), .IFU_LEN(4)) dut_b (.clock(clock), .reset(reset), .bus(b.slave));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] sram_model(input logic [31:0] addr);
        if (addr == 32'h8000_0000) return 32'h0000_0413;
        return (addr ^ 32'h5A5A_0000) + 32'h11;
    endfunction

    assign a.mem_rdata = sram_model(a.mem_addr);
    assign b.mem_rdata = sram_model(b.mem_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor for dut_a (resp_ready held high throughout)
    txn_t e;
    logic hs_pending  = 1'b0;
    logic prev_strobe = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clock) begin
        if (!reset) begin
            hs_pending  = 1'b0;
            prev_strobe = 1'b0;
            prev_addr   = a.mem_addr;
        end else begin
            if (a.mem_load || a.mem_store) begin
                check("strobe_one_cycle", prev_strobe, 1'b0);
                check("strobe_expected", q_strb.size() != 0, 1'b1);
                if (q_strb.size() != 0) begin
                    e = q_strb.pop_front();
                    check("strobe_kind", {a.mem_load, a.mem_store}, {!e.wen, e.wen});
                    check("strobe_addr", a.mem_addr, e.addr);
                    check("strobe_len", a.mem_len, e.len);
                    check("strobe_wdata", a.mem_wdata, e.wdata);
                    check("strobe_latency", cyc - e.cyc, 1);
                end
            end
            prev_strobe = a.mem_load || a.mem_store;

            if (a.mem_addr !== prev_addr) check("addr_change_on_hs", hs_pending, 1'b1);
            prev_addr = a.mem_addr;

            if (a.ifu_resp_valid || a.lsu_resp_valid) begin
                check("single_resp", a.ifu_resp_valid && a.lsu_resp_valid, 1'b0);
                check("resp_expected", q_resp.size() != 0, 1'b1);
                if (q_resp.size() != 0) begin
                    e = q_resp.pop_front();
                    check("resp_owner", a.lsu_resp_valid, e.owner);
                    check("resp_latency", cyc - e.cyc, 1 + L_A);
                    check("resp_data", e.owner ? a.lsu_resp_data : a.ifu_resp_data, e.rdata);
                end
            end

            hs_pending = 1'b0;
            if ((a.ifu_req_valid && a.ifu_req_ready) || (a.lsu_req_valid && a.lsu_req_ready)) begin
                hs_pending = 1'b1;
                check("single_grant", a.ifu_req_ready && a.lsu_req_ready, 1'b0);
                e.owner = a.lsu_req_valid && a.lsu_req_ready;
                check("grant_expected", q_grant.size() != 0, 1'b1);
                if (q_grant.size() != 0) check("grant_owner", e.owner, q_grant.pop_front());
                e.wen   = e.owner ? a.lsu_req_wen : 1'b0;
                e.addr  = e.owner ? a.lsu_req_addr : a.ifu_req_addr;
                e.len   = e.owner ? a.lsu_req_len : 32'd4;
                e.wdata = e.owner ? a.lsu_req_wdata : 32'd0;
                e.rdata = e.wen ? 32'd0 : sram_model(e.addr);
                e.cyc   = cyc;
                q_strb.push_back(e);
                q_resp.push_back(e);
            end
        end
    end

    // Drive one request on dut_a and hold it until accepted.
    task automatic a_req(input logic is_lsu, input logic wen, input logic [31:0] addr,
                         input logic [31:0] len, input logic [31:0] wdata);
        logic got;
        got = 1'b0;
        q_grant.push_back(is_lsu);
        if (is_lsu) begin
            a.lsu_req_valid = 1'b1;
            a.lsu_req_wen   = wen;
            a.lsu_req_addr  = addr;
            a.lsu_req_len   = len;
            a.lsu_req_wdata = wdata;
        end else begin
            a.ifu_req_valid = 1'b1;
            a.ifu_req_addr  = addr;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            got = is_lsu ? a.lsu_req_ready : a.ifu_req_ready;
            @(posedge clock); #2;
        end
        check("req_accepted", got, 1'b1);
        a.ifu_req_valid = 1'b0;
        a.lsu_req_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (q_resp.size() != 0 && i < 50) begin
            @(posedge clock);
            i++;
        end
        check("drain", q_resp.size(), 0);
        @(posedge clock); #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no summary, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n_hs;
        int   last;
        int   n_st;
        int   n_rv;
        logic got;

        a.ifu_req_valid = 0; a.ifu_req_addr = '0; a.ifu_resp_ready = 1;
        a.lsu_req_valid = 0; a.lsu_req_wen = 0; a.lsu_req_addr = '0;
        a.lsu_req_len = '0; a.lsu_req_wdata = '0; a.lsu_resp_ready = 1;
        b.ifu_req_valid = 0; b.ifu_req_addr = '0; b.ifu_resp_ready = 0;
        b.lsu_req_valid = 0; b.lsu_req_wen = 0; b.lsu_req_addr = '0;
        b.lsu_req_len = '0; b.lsu_req_wdata = '0; b.lsu_resp_ready = 1;

        // Reset values, with requests pending so ready gating is observable
        a.ifu_req_valid = 1;
        b.lsu_req_valid = 1;
        #3;
        check("rst_ifu_req_ready", a.ifu_req_ready, 1'b0);
        check("rst_lsu_req_ready", b.lsu_req_ready, 1'b0);
        check("rst_mem_strobes", {a.mem_load, a.mem_store}, 2'b00);
        check("rst_mem_addr", a.mem_addr, 32'd0);
        check("rst_mem_len", a.mem_len, 32'd0);
        check("rst_mem_wdata", a.mem_wdata, 32'd0);
        check("rst_resp_valid", {a.ifu_resp_valid, a.lsu_resp_valid}, 2'b00);
        check("rst_resp_data", a.ifu_resp_data, 32'd0);
        a.ifu_req_valid = 0;
        b.lsu_req_valid = 0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock); #2;

        // Single IFU fetch, store, load
        a_req(1'b0, 1'b0, 32'h8000_0000, 32'd0, 32'd0);
        drain();
        a_req(1'b1, 1'b1, 32'h8000_1000, 32'd4, 32'hDEAD_BEEF);
        drain();
        a_req(1'b1, 1'b0, 32'h8000_2004, 32'd2, 32'd0);
        drain();

        // Both masters valid continuously: strict alternation starting with IFU
        for (int k = 0; k < 6; k++) q_grant.push_back(k % 2 == 1);
        a.ifu_req_valid = 1; a.ifu_req_addr = 32'h8000_0100;
        a.lsu_req_valid = 1; a.lsu_req_wen = 0; a.lsu_req_addr = 32'h8000_0200;
        a.lsu_req_len = 32'd4; a.lsu_req_wdata = 32'd0;
        n_hs = 0;
        for (int i = 0; i < 60 && n_hs < 6; i++) begin
            @(negedge clock);
            if (a.ifu_req_ready || a.lsu_req_ready) n_hs++;
            @(posedge clock); #2;
        end
        a.ifu_req_valid = 0;
        a.lsu_req_valid = 0;
        check("alt_handshakes", n_hs, 6);
        drain();

        // Back-to-back IFU fetches: one handshake every LATENCY+2 cycles
        for (int k = 0; k < 4; k++) q_grant.push_back(1'b0);
        a.ifu_req_valid = 1; a.ifu_req_addr = 32'h8000_0300;
        n_hs = 0;
        last = 0;
        for (int i = 0; i < 60 && n_hs < 4; i++) begin
            @(negedge clock);
            got = a.ifu_req_ready;
            if (got) begin
                if (n_hs > 0) check("b2b_interval", cyc - last, 3);
                last = cyc;
                n_hs++;
            end
            @(posedge clock); #2;
            if (got) a.ifu_req_addr = a.ifu_req_addr + 32'd4;
        end
        a.ifu_req_valid = 0;
        check("b2b_handshakes", n_hs, 4);
        drain();

        // LATENCY=3 instance: response timing and stall with resp_ready low
        b.ifu_req_valid = 1; b.ifu_req_addr = 32'h8000_0040;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            got = b.ifu_req_ready;
            @(posedge clock); #2;
        end
        check("b_req_accepted", got, 1'b1);
        b.ifu_req_valid = 0;
        b.lsu_req_valid = 1; b.lsu_req_wen = 1; b.lsu_req_addr = 32'h8000_1000;
        b.lsu_req_len = 32'd4; b.lsu_req_wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        check("b_strobe_load", {b.mem_load, b.mem_store}, 2'b10);
        check("b_strobe_len", b.mem_len, 32'd4);
        repeat (2) begin
            @(negedge clock);
            check("b_resp_early", b.ifu_resp_valid, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("b_resp_valid_held", b.ifu_resp_valid, 1'b1);
            check("b_resp_data_held", b.ifu_resp_data, sram_model(32'h8000_0040));
            check("b_no_grant_in_resp", b.lsu_req_ready, 1'b0);
            check("b_other_resp_low", b.lsu_resp_valid, 1'b0);
        end
        #1 b.ifu_resp_ready = 1;
        @(posedge clock); #2;
        b.ifu_resp_ready = 0;
        @(negedge clock);
        check("b_resp_released", b.ifu_resp_valid, 1'b0);
        check("b_lsu_granted", b.lsu_req_ready, 1'b1);
        @(posedge clock); #2;
        b.lsu_req_valid = 0;

        // Reset in the middle of the store's ACCESS phase
        @(negedge clock);
        check("b_store_strobe", {b.mem_load, b.mem_store}, 2'b01);
        check("b_store_wdata", b.mem_wdata, 32'hDEAD_BEEF);
        @(negedge clock);
        #2;
        b.lsu_req_valid = 1;
        reset = 1'b0;
        #1;
        check("mid_rst_strobe", {b.mem_load, b.mem_store}, 2'b00);
        check("mid_rst_addr", b.mem_addr, 32'd0);
        check("mid_rst_wdata", b.mem_wdata, 32'd0);
        check("mid_rst_req_ready", b.lsu_req_ready, 1'b0);
        check("mid_rst_resp", {b.ifu_resp_valid, b.lsu_resp_valid}, 2'b00);
        b.lsu_req_valid = 0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        n_st = 0;
        n_rv = 0;
        repeat (8) begin
            @(negedge clock);
            if (b.mem_store) n_st++;
            if (b.lsu_resp_valid) n_rv++;
        end
        check("no_store_after_rst", n_st, 0);
        check("no_resp_after_rst", n_rv, 0);

        repeat (3) @(posedge clock);
        check("strobes_all_seen", q_strb.size(), 0);
        check("grants_all_seen", q_grant.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
